// File: rtl/seg_pkg.sv
`default_nettype none
// seg_pkg: digit-entry type, scan FSM states and the active-low 7-segment decoder
// shared by the display scan scheduler.
package seg_pkg;

  typedef struct packed {
    logic       en;
    logic       dot;
    logic [3:0] hex;
  } seg_entry_t;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_t;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_OFF    = 8'hFF;

  // Returns {dp,g,f,e,d,c,b,a} active-low; a disabled entry is fully dark, dot included.
  function automatic logic [7:0] seg_decode(input seg_entry_t e);
    logic [6:0] gfedcba;
    gfedcba = 7'h00;
    case (e.hex)
      4'h0: gfedcba = 7'h3F;
      4'h1: gfedcba = 7'h06;
      4'h2: gfedcba = 7'h5B;
      4'h3: gfedcba = 7'h4F;
      4'h4: gfedcba = 7'h66;
      4'h5: gfedcba = 7'h6D;
      4'h6: gfedcba = 7'h7D;
      4'h7: gfedcba = 7'h07;
      4'h8: gfedcba = 7'h7F;
      4'h9: gfedcba = 7'h6F;
      4'hA: gfedcba = 7'h77;
      4'hB: gfedcba = 7'h7C;
      4'hC: gfedcba = 7'h39;
      4'hD: gfedcba = 7'h5E;
      4'hE: gfedcba = 7'h79;
      4'hF: gfedcba = 7'h71;
    endcase
    if (!e.en) seg_decode = SEG_OFF;
    else       seg_decode = ~{e.dot, gfedcba};
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_rr_arbiter.sv
`default_nettype none
// seg_rr_arbiter: two-way round-robin arbiter with registered one-hot grants.
// Priority only alternates when both requesters contend in the same cycle.
module seg_rr_arbiter (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  logic prio_b;
  logic live_a;
  logic live_b;
  logic both;
  logic gnt_a_nxt;
  logic gnt_b_nxt;

  // A request still high during its own grant cycle is the handshake tail, not a new request.
  always_comb begin
    live_a    = i_req_a & ~o_gnt_a;
    live_b    = i_req_b & ~o_gnt_b;
    both      = live_a & live_b;
    gnt_a_nxt = live_a & (~live_b | ~prio_b);
    gnt_b_nxt = live_b & (~live_a |  prio_b);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_gnt_a <= 1'b0;
      o_gnt_b <= 1'b0;
      prio_b  <= 1'b0;
    end else begin
      o_gnt_a <= gnt_a_nxt;
      o_gnt_b <= gnt_b_nxt;
      if (both) prio_b <= ~prio_b;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// seg_scan_scheduler: 8-digit multiplexed 7-seg driver with inter-digit blanking and a
// round-robin shared digit buffer for two writers.
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int F_CLK     = 50_000_000,
  parameter int F_SCAN    = 8_000,
  parameter int BLANK_CYC = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_a,
  input  logic [2:0] i_idx_a,
  input  logic [5:0] i_dat_a,
  output logic       o_gnt_a,
  input  logic       i_req_b,
  input  logic [2:0] i_idx_b,
  input  logic [5:0] i_dat_b,
  output logic       o_gnt_b,
  output logic [7:0] o_cs,
  output logic [7:0] o_dig_sel
);

  localparam int              DIV        = F_CLK / F_SCAN;
  localparam int              TW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int              BW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [TW-1:0]   TICK_LAST  = TW'(DIV - 1);
  localparam logic [BW-1:0]   BLANK_LAST = BW'(BLANK_CYC - 1);

  logic [TW-1:0] tick_cnt;
  logic          scan_tick;
  scan_state_t   state;
  scan_state_t   state_nxt;
  logic [BW-1:0] blank_cnt;
  logic [BW-1:0] blank_cnt_nxt;
  logic [2:0]    ptr;
  logic [2:0]    ptr_nxt;
  seg_entry_t    entries [NUM_DIGITS];
  logic          wr_en;
  logic [2:0]    wr_idx;
  seg_entry_t    wr_dat;
  seg_entry_t    view;
  logic [7:0]    cs_nxt;
  logic [7:0]    seg_nxt;

  seg_rr_arbiter u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req_a (i_req_a),
    .i_req_b (i_req_b),
    .o_gnt_a (o_gnt_a),
    .o_gnt_b (o_gnt_b)
  );

  assign scan_tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) tick_cnt <= '0;
    else          tick_cnt <= scan_tick ? '0 : tick_cnt + TW'(1);
  end

  // The granted writer is still holding its idx/dat during the grant cycle.
  always_comb begin
    wr_en  = o_gnt_a | o_gnt_b;
    wr_idx = o_gnt_a ? i_idx_a : i_idx_b;
    wr_dat = o_gnt_a ? seg_entry_t'(i_dat_a) : seg_entry_t'(i_dat_b);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) entries[i] <= '0;
    end else if (wr_en) begin
      entries[wr_idx] <= wr_dat;
    end
  end

  always_comb begin
    state_nxt     = state;
    blank_cnt_nxt = blank_cnt;
    ptr_nxt       = ptr;
    case (state)
      S_BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          state_nxt     = S_SHOW;
          blank_cnt_nxt = '0;
          ptr_nxt       = ptr + 3'd1;
        end else begin
          blank_cnt_nxt = blank_cnt + BW'(1);
        end
      end
      S_SHOW: begin
        if (scan_tick) state_nxt = S_BLANK;
      end
    endcase

    // Bypass the write port so a write to the shown digit lands one cycle after its grant.
    view    = (wr_en && (wr_idx == ptr_nxt)) ? wr_dat : entries[ptr_nxt];
    cs_nxt  = 8'hFF;
    seg_nxt = SEG_OFF;
    if (state_nxt == S_SHOW) begin
      cs_nxt  = ~(8'b1 << ptr_nxt);
      seg_nxt = seg_decode(view);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_BLANK;
      blank_cnt <= '0;
      ptr       <= '0;
      o_cs      <= 8'hFF;
      o_dig_sel <= SEG_OFF;
    end else begin
      state     <= state_nxt;
      blank_cnt <= blank_cnt_nxt;
      ptr       <= ptr_nxt;
      o_cs      <= cs_nxt;
      o_dig_sel <= seg_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_scheduler.sv
`default_nettype none
// tb_seg_scan_scheduler: directed table-driven bench for the 7-seg scan scheduler
// (8-cycle digit slot, 2-cycle blanking gap).
module tb_seg_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_a = 1'b0;
  logic [2:0] idx_a = '0;
  logic [5:0] dat_a = '0;
  logic       gnt_a;
  logic       req_b = 1'b0;
  logic [2:0] idx_b = '0;
  logic [5:0] dat_b = '0;
  logic       gnt_b;
  logic [7:0] cs;
  logic [7:0] dig;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       use_b;
    logic [2:0] idx;
    logic [5:0] dat;
    logic [7:0] exp_seg;
  } vec_t;

  vec_t vecs [7];

  seg_scan_scheduler #(
    .F_CLK     (800),
    .F_SCAN    (100),
    .BLANK_CYC (2)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req_a   (req_a),
    .i_idx_a   (idx_a),
    .i_dat_a   (dat_a),
    .o_gnt_a   (gnt_a),
    .i_req_b   (req_b),
    .i_idx_b   (idx_b),
    .i_dat_b   (dat_b),
    .o_gnt_b   (gnt_b),
    .o_cs      (cs),
    .o_dig_sel (dig)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Called right after reset release at a negedge; k counts posedges since release.
  task automatic scan_check(input string tag);
    logic [7:0] sel;
    logic [7:0] exp_cs;
    check({tag, "_rst_cs"}, cs, 8'hFF);
    check({tag, "_rst_dig"}, dig, 8'hFF);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      sel    = 8'b1 << ((k / 8 + 1) % 8);
      exp_cs = ((k % 8) >= 2) ? ~sel : 8'hFF;
      check({tag, "_cs"}, cs, exp_cs);
      check({tag, "_dig"}, dig, 8'hFF);
    end
  endtask

  task automatic write_entry(input logic use_b, input logic [2:0] idx, input logic [5:0] dat);
    if (use_b) begin idx_b = idx; dat_b = dat; req_b = 1'b1; end
    else       begin idx_a = idx; dat_a = dat; req_a = 1'b1; end
    @(negedge clk);
    check("gnt_latency", {7'b0, use_b ? gnt_b : gnt_a}, 8'h01);
    @(negedge clk);
    check("gnt_once", {7'b0, use_b ? gnt_b : gnt_a}, 8'h00);
    if (use_b) req_b = 1'b0;
    else       req_a = 1'b0;
  endtask

  // Lands on the first SHOW cycle of digit idx.
  task automatic wait_digit(input logic [2:0] idx, input string name);
    logic [7:0] sel;
    logic       found;
    sel   = ~(8'b1 << idx);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (cs == 8'hFF) found = 1'b1;
    end
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (cs == sel) found = 1'b1;
    end
    check({name, "_seen"}, {7'b0, found}, 8'h01);
  endtask

  task automatic collide(input logic [5:0] da, input logic [5:0] db, input logic b_first, input string name);
    idx_a = 3'd2; dat_a = da; req_a = 1'b1;
    idx_b = 3'd2; dat_b = db; req_b = 1'b1;
    @(negedge clk);
    check({name, "_g1"}, {6'b0, gnt_a, gnt_b}, b_first ? 8'h01 : 8'h02);
    @(negedge clk);
    check({name, "_g2"}, {6'b0, gnt_a, gnt_b}, b_first ? 8'h02 : 8'h01);
    if (b_first) req_b = 1'b0;
    else         req_a = 1'b0;
    @(negedge clk);
    check({name, "_g3"}, {6'b0, gnt_a, gnt_b}, 8'h00);
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    check({name, "_g4"}, {6'b0, gnt_a, gnt_b}, 8'h00);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{use_b: 1'b0, idx: 3'd3, dat: 6'h25, exp_seg: 8'h92};
    vecs[1] = '{use_b: 1'b1, idx: 3'd6, dat: 6'h3A, exp_seg: 8'h08};
    vecs[2] = '{use_b: 1'b0, idx: 3'd0, dat: 6'h28, exp_seg: 8'h80};
    vecs[3] = '{use_b: 1'b1, idx: 3'd7, dat: 6'h30, exp_seg: 8'h40};
    vecs[4] = '{use_b: 1'b0, idx: 3'd1, dat: 6'h2F, exp_seg: 8'h8E};
    vecs[5] = '{use_b: 1'b1, idx: 3'd4, dat: 6'h17, exp_seg: 8'hFF};
    vecs[6] = '{use_b: 1'b0, idx: 3'd5, dat: 6'h3D, exp_seg: 8'h21};

    repeat (3) @(negedge clk);
    check("rst_gnt", {6'b0, gnt_a, gnt_b}, 8'h00);
    rst_n = 1'b1;
    scan_check("boot");

    for (int v = 0; v < 7; v++) write_entry(vecs[v].use_b, vecs[v].idx, vecs[v].dat);
    for (int v = 0; v < 7; v++) begin
      logic [7:0] sel;
      sel = 8'b1 << vecs[v].idx;
      wait_digit(vecs[v].idx, "vec");
      check("vec_cs", cs, ~sel);
      check("vec_dig", dig, vecs[v].exp_seg);
    end

    collide(6'h21, 6'h22, 1'b0, "coll1");
    wait_digit(3'd2, "coll1_dig");
    check("coll1_val", dig, 8'hA4);
    collide(6'h23, 6'h24, 1'b1, "coll2");
    wait_digit(3'd2, "coll2_dig");
    check("coll2_val", dig, 8'hB0);

    wait_digit(3'd3, "live");
    check("live_old", dig, 8'h92);
    idx_a = 3'd3; dat_a = 6'h21; req_a = 1'b1;
    @(negedge clk);
    check("live_gnt", {7'b0, gnt_a}, 8'h01);
    check("live_pre", dig, 8'h92);
    @(negedge clk);
    req_a = 1'b0;
    check("live_new", dig, 8'hF9);
    check("live_cs", cs, 8'hF7);

    write_entry(1'b0, 3'd0, 6'h18);
    wait_digit(3'd0, "off");
    check("off_cs", cs, 8'hFE);
    check("off_dig", dig, 8'hFF);

    wait_digit(3'd5, "rst");
    check("rst_pre", dig, 8'h21);
    idx_a = 3'd5; dat_a = 6'h28; req_a = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_cs", cs, 8'hFF);
    check("rst_async_dig", dig, 8'hFF);
    check("rst_async_gnt", {7'b0, gnt_a}, 8'h00);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_gnt", {7'b0, gnt_a}, 8'h00);
    end
    req_a = 1'b0;
    rst_n = 1'b1;
    scan_check("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
